// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen
//   Multi-channel PWM generator. A single shared period counter drives
//   CHANNELS duty comparators. Range and duty updates are double-buffered
//   and take effect only at period boundaries, so no output ever shows a
//   truncated or glitched pulse.
//
//   Optional feature macro: PWM_CENTER_ALIGN_EN
//     defined   -> adds input pwm_center, selecting up/down (center-aligned)
//                  counting.
//     undefined -> edge-aligned counting only, with no direction register.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset
//   pwm_en       global enable
//   pwm_range    period terminal count (edge mode period = range+1)
//   pwm_value    per-channel duty, channel i at [i*WIDTH +: WIDTH]
//   pwm_load     single-cycle strobe capturing pwm_range/pwm_value
//   pwm_center   (PWM_CENTER_ALIGN_EN only) 1 selects up/down counting
//   pwm_pending  buffered update waiting for the next boundary
//   pwm_period   one-cycle pulse on the last cycle of each period
//   pwm_out      PWM outputs
module pwm_multi_gen #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pwm_en,
    input  logic [WIDTH-1:0]          pwm_range,
    input  logic [CHANNELS*WIDTH-1:0] pwm_value,
    input  logic                      pwm_load,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic                      pwm_center,
`endif
    output logic                      pwm_pending,
    output logic                      pwm_period,
    output logic [CHANNELS-1:0]       pwm_out
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]          cnt;
    logic [WIDTH-1:0]          cnt_nxt;
    logic [WIDTH-1:0]          range_a;
    logic [WIDTH-1:0]          range_b;
    logic [CHANNELS*WIDTH-1:0] value_a;
    logic [CHANNELS*WIDTH-1:0] value_b;
    logic [CHANNELS-1:0]       cmp;
    logic                      boundary;
    logic                      apply;

`ifdef PWM_CENTER_ALIGN_EN
    logic center_a;
    logic dir_down;
    logic dir_down_nxt;
`endif

    // Last count of the period. In center mode the period ends on cnt 1
    // while heading down; with range 1 the turnaround point is itself cnt 1,
    // and range 0 collapses to a boundary every cycle.
    always_comb begin
`ifdef PWM_CENTER_ALIGN_EN
        if (center_a)
            boundary = (range_a == '0) ||
                       ((cnt == ONE) && (dir_down || (range_a == ONE)));
        else
            boundary = (cnt == range_a);
`else
        boundary = (cnt == range_a);
`endif
    end

    // A disabled cycle behaves like a boundary: the counter is parked at 0
    // and updates go straight to the active registers.
    assign apply = !pwm_en || boundary;

    always_comb begin
        cnt_nxt = cnt;
`ifdef PWM_CENTER_ALIGN_EN
        dir_down_nxt = dir_down;
`endif
        if (apply) begin
            cnt_nxt = '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_nxt = 1'b0;
`endif
        end
`ifdef PWM_CENTER_ALIGN_EN
        else if (center_a && dir_down) begin
            cnt_nxt = cnt - ONE;
        end
        else if (center_a && (cnt == range_a)) begin
            cnt_nxt      = cnt - ONE;
            dir_down_nxt = 1'b1;
        end
`endif
        else begin
            cnt_nxt = cnt + ONE;
        end
    end

    always_comb begin
        cmp = '0;
        for (int i = 0; i < CHANNELS; i++)
            cmp[i] = (cnt < value_a[i*WIDTH +: WIDTH]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down <= 1'b0;
`endif
        end else begin
            cnt <= cnt_nxt;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down <= dir_down_nxt;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            range_a     <= '1;
            range_b     <= '1;
            value_a     <= '0;
            value_b     <= '0;
            pwm_pending <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            center_a    <= 1'b0;
`endif
        end else if (apply) begin
            // A load landing on the boundary (or while disabled) wins over
            // any older buffered update.
            if (pwm_load) begin
                range_a <= pwm_range;
                value_a <= pwm_value;
            end else if (pwm_pending) begin
                range_a <= range_b;
                value_a <= value_b;
            end
            pwm_pending <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            center_a    <= pwm_center;
`endif
        end else if (pwm_load) begin
            range_b     <= pwm_range;
            value_b     <= pwm_value;
            pwm_pending <= 1'b1;
        end
    end

    // Outputs are registered so they lag cnt by exactly one cycle, keeping
    // pwm_period aligned with the final slot of pwm_out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_out    <= '0;
            pwm_period <= 1'b0;
        end else begin
            pwm_out    <= pwm_en ? cmp : '0;
            pwm_period <= pwm_en & boundary;
        end
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
module tb_pwm_multi_gen;

    localparam int W  = 8;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            tb_en;
    logic [W-1:0]    tb_range;
    logic [CH*W-1:0] tb_val;
    logic            tb_load;
    logic            tb_center;
    logic            pwm_pending;
    logic            pwm_period;
    logic [CH-1:0]   pwm_out;

    always #5 clk = ~clk;

    pwm_multi_gen #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_en      (tb_en),
        .pwm_range   (tb_range),
        .pwm_value   (tb_val),
        .pwm_load    (tb_load),
`ifdef PWM_CENTER_ALIGN_EN
        .pwm_center  (tb_center),
`endif
        .pwm_pending (pwm_pending),
        .pwm_period  (pwm_period),
        .pwm_out     (pwm_out)
    );

    int n_pass  = 0;
    int n_total = 0;
    int hi_cnt  = 0;

    // Reference model: position within the period plus the active/buffered
    // settings; counts are derived arithmetically from the position.
    int            mp;
    int            mr;
    int            mv [CH];
    int            br;
    int            bv [CH];
    bit            mpend;
    bit            mcen;
    logic [CH-1:0] exp_out;
    logic          exp_per;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_init();
        mp    = 0;
        mr    = (1 << W) - 1;
        br    = (1 << W) - 1;
        mpend = 0;
        mcen  = 0;
        for (int i = 0; i < CH; i++) begin
            mv[i] = 0;
            bv[i] = 0;
        end
    endtask

    function automatic int mlen();
        if (mcen) return (mr == 0) ? 1 : 2 * mr;
        return mr + 1;
    endfunction

    function automatic int mcount(input int p);
        if (mcen && p > mr) return 2 * mr - p;
        return p;
    endfunction

    task automatic model_step();
        int c;
        bit bnd;
        int nxt;
        if (!tb_en) begin
            exp_out = '0;
            exp_per = 1'b0;
            bnd     = 1;
            nxt     = 0;
        end else begin
            c = mcount(mp);
            for (int i = 0; i < CH; i++) exp_out[i] = (c < mv[i]);
            bnd     = (mp == mlen() - 1);
            exp_per = bnd;
            nxt     = bnd ? 0 : mp + 1;
        end
        if (bnd) begin
            if (tb_load) begin
                mr = int'(tb_range);
                for (int i = 0; i < CH; i++) mv[i] = int'(tb_val[i*W +: W]);
            end else if (mpend) begin
                mr = br;
                for (int i = 0; i < CH; i++) mv[i] = bv[i];
            end
            mpend = 0;
            mcen  = tb_center;
        end else if (tb_load) begin
            br = int'(tb_range);
            for (int i = 0; i < CH; i++) bv[i] = int'(tb_val[i*W +: W]);
            mpend = 1;
        end
        mp = nxt;
    endtask

    task automatic do_cycle();
        model_step();
        @(posedge clk);
        #1;
        check("pwm_out", 32'(pwm_out), 32'(exp_out));
        check("pwm_period", 32'(pwm_period), 32'(exp_per));
        check("pwm_pending", 32'(pwm_pending), 32'(mpend));
        hi_cnt += int'(pwm_out[1]);
    endtask

    task automatic set_vals(input int a, input int b, input int c, input int d);
        tb_val = {d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
    endtask

    task automatic run_to(input int p);
        for (int k = 0; k < 600 && mp != p; k++) do_cycle();
    endtask

    initial begin
        reset     = 1'b0;
        tb_en     = 1'b0;
        tb_load   = 1'b0;
        tb_center = 1'b0;
        tb_range  = '0;
        tb_val    = '0;
        #12;
        check("reset_out", 32'(pwm_out), 32'd0);
        check("reset_period", 32'(pwm_period), 32'd0);
        check("reset_pending", 32'(pwm_pending), 32'd0);
        reset = 1'b1;
        model_init();

        // Basic: range 9, values {0,3,10,255}, loaded while disabled.
        tb_range = 8'd9;
        set_vals(0, 3, 10, 255);
        tb_load = 1'b1;
        do_cycle();
        tb_load = 1'b0;
        tb_en   = 1'b1;
        hi_cnt  = 0;
        for (int k = 0; k < 10; k++) do_cycle();
        check("basic_ch1_high", 32'(hi_cnt), 32'd3);
        check("basic_period_last", 32'(pwm_period), 32'd1);

        // Mid-period load at cnt 4 with ch1=7.
        hi_cnt = 0;
        run_to(4);
        set_vals(0, 7, 10, 255);
        tb_load = 1'b1;
        do_cycle();
        tb_load = 1'b0;
        check("mid_load_pending", 32'(pwm_pending), 32'd1);
        run_to(9);
        check("pending_before_bnd", 32'(pwm_pending), 32'd1);
        do_cycle();
        check("pending_after_bnd", 32'(pwm_pending), 32'd0);
        check("mid_cur_period_high", 32'(hi_cnt), 32'd3);
        hi_cnt = 0;
        for (int k = 0; k < 10; k++) do_cycle();
        check("mid_next_period_high", 32'(hi_cnt), 32'd7);

        // Load on the boundary cycle with ch1=5.
        run_to(9);
        set_vals(0, 5, 10, 255);
        tb_load = 1'b1;
        do_cycle();
        tb_load = 1'b0;
        check("bnd_load_no_pending", 32'(pwm_pending), 32'd0);
        hi_cnt = 0;
        for (int k = 0; k < 10; k++) do_cycle();
        check("bnd_load_high", 32'(hi_cnt), 32'd5);

        // Asynchronous reset at cnt 6 while all outputs are high.
        set_vals(200, 200, 200, 200);
        tb_load = 1'b1;
        do_cycle();
        tb_load = 1'b0;
        run_to(0);
        run_to(6);
        do_cycle();
        check("pre_reset_out", 32'(pwm_out), 32'hF);
        #2 reset = 1'b0;
        #1;
        check("async_reset_out", 32'(pwm_out), 32'd0);
        check("async_reset_pending", 32'(pwm_pending), 32'd0);
        @(posedge clk);
        #1;
        check("held_reset_out", 32'(pwm_out), 32'd0);
        reset = 1'b1;
        model_init();
        hi_cnt = 0;
        for (int k = 0; k < 256; k++) do_cycle();
        check("post_reset_period", 32'(pwm_period), 32'd1);
        check("post_reset_high", 32'(hi_cnt), 32'd0);

        // Disable at cnt 3, load while disabled, re-enable.
        run_to(3);
        tb_en = 1'b0;
        do_cycle();
        tb_range = 8'd3;
        set_vals(2, 2, 2, 2);
        tb_load = 1'b1;
        do_cycle();
        tb_load = 1'b0;
        check("dis_load_pending", 32'(pwm_pending), 32'd0);
        tb_en  = 1'b1;
        hi_cnt = 0;
        for (int k = 0; k < 4; k++) do_cycle();
        check("reen_high", 32'(hi_cnt), 32'd2);
        check("reen_period", 32'(pwm_period), 32'd1);

`ifdef PWM_CENTER_ALIGN_EN
        // Center-aligned: range 4, value 2 gives an 8-cycle period, 3 high.
        tb_en     = 1'b0;
        tb_center = 1'b1;
        tb_range  = 8'd4;
        set_vals(2, 2, 2, 2);
        tb_load = 1'b1;
        do_cycle();
        tb_load = 1'b0;
        tb_en   = 1'b1;
        hi_cnt  = 0;
        for (int k = 0; k < 8; k++) do_cycle();
        check("center_high", 32'(hi_cnt), 32'd3);
        check("center_period", 32'(pwm_period), 32'd1);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            int r;
            tb_en   = ($urandom_range(0, 29) != 0);
            tb_load = ($urandom_range(0, 7) == 0);
            r = int'($urandom_range(0, 12));
            tb_range = r[W-1:0];
            for (int i = 0; i < CH; i++) begin
                int v;
                v = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, r + 2));
                tb_val[i*W +: W] = v[W-1:0];
            end
`ifdef PWM_CENTER_ALIGN_EN
            tb_center = 1'($urandom_range(0, 1));
`endif
            do_cycle();
        end
        tb_load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pwm_multi_gen.md
# pwm_multi_gen

Multi-channel, parameterised PWM generator; successor to the single 8-bit PWM channel. One shared period counter drives CHANNELS independent duty comparators. Duty and range updates are double-buffered and take effect only at period boundaries, so no output produces a truncated or glitched pulse. Sits behind the register/driver layer and feeds pad-level PWM outputs.

## Interface

- WIDTH, 8, counter, range and duty width in bits (2..16)
- CHANNELS, 4, number of PWM outputs (1..16)

- clk  input  1  sole clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset
- pwm_en  input  1  global enable
- pwm_range  input  WIDTH  period terminal count (edge mode: period = range+1 cycles)
- pwm_value  input  CHANNELS*WIDTH  per-channel duty; channel i at [i*WIDTH +: WIDTH]
- pwm_load  input  1  single-cycle strobe capturing pwm_range/pwm_value into buffer
- pwm_pending  output  1  buffered update waiting for next boundary
- pwm_period  output  1  one-cycle pulse on last cycle of each period
- pwm_out  output  CHANNELS  PWM outputs

## Operation

- Reset values: cnt 0, direction up, active range and buffer range all ones, active and buffer values 0, pwm_pending 0, pwm_period 0, pwm_out 0.
- Reset is asynchronous: asserting it mid-period clears all state immediately, with no wait for clk.
- Edge mode counter sequence: 0,1,…,range_a, then back to 0. range_a 0 gives cnt held at 0 and a boundary every cycle.
- Boundary cycle: the cycle in which cnt is the last count of the period.
- Compare: channel i is high when cnt < value_a[i].
  - value 0 gives constant low.
  - value > range_a gives constant high (100 %).
  - Duty = value/(range+1).
- pwm_load:
  - Captures the inputs into the buffer and sets pending.
  - At the next boundary the buffer is copied to the active registers and pending clears.
  - A second load before the boundary overwrites the buffer.
- pwm_load on a boundary cycle bypasses the buffer: the inputs go straight to the active registers for the next period, and pending stays 0.
- pwm_en low:
  - cnt is held at 0, direction is set to up, and pwm_out and pwm_period are 0.
  - pwm_load updates the active registers directly, and pending is cleared.
  - When pwm_en rises, that cycle is cnt 0 of a fresh period.
- Arithmetic is unsigned WIDTH-bit. The counter never exceeds range_a.

## Timing

- pwm_out and pwm_period are registered and lag cnt by exactly one cycle. Both reflect the same count, so pwm_period and the final slot of pwm_out coincide.
- Active registers change at the clk edge ending the boundary cycle. The new values govern compares from cnt 0 onward, and appear on outputs one cycle later.
- pwm_pending rises the cycle after a non-boundary pwm_load. It falls the cycle after the boundary.
- pwm_en falling: pwm_out and pwm_period are 0 from the next cycle.

## Configuration

- PWM_CENTER_ALIGN_EN: when defined, the block adds input port pwm_center (1 bit). pwm_center is sampled only at boundaries and while disabled.
- pwm_center=1 selects up/down counting:
  - Sequence 0,1,…,range_a,range_a−1,…,1, giving period 2*range_a cycles.
  - The boundary is cnt 1 while counting down.
  - range_a 0 degenerates to cnt held at 0 with a boundary every cycle.
- When undefined: the port is absent, the direction register is removed, and the block is edge-aligned only.

## Test plan

- WIDTH=8, CHANNELS=4: load range 9, values {0,3,10,255}, pwm_en=1.
  - pwm_period pulses every 10 cycles.
  - ch0 stays 0.
  - ch1 is high 3 of 10 cycles, starting on the cycle after the period pulse.
  - ch2 and ch3 stay 1.
- Mid-period (cnt 4) pwm_load with ch1=7:
  - pwm_pending goes 1.
  - The current period keeps 3 high cycles.
  - The next period has 7.
  - pwm_pending drops the cycle after the boundary.
- pwm_load with ch1=5 on a boundary cycle: the next period has ch1 high 5 cycles, and pwm_pending never asserts.
- PWM_CENTER_ALIGN_EN, pwm_center=1, range 4, value 2: period 8 cycles, with cnt 0,1,2,3,4,3,2,1; out is high 3 of 8.
- Reset low at cnt 6 with outputs high: pwm_out goes 0 at once, without a clk edge. After release with pwm_en=1, the counter runs from 0 with range 255 and all outputs stay 0.
- pwm_en dropped at cnt 3, then pwm_load with range 3, values all 2, then pwm_en raised: the update applies immediately, and the first period is 4 cycles with outputs high for 2.
